// File: rtl/seq_exec_unit.sv
// Execute/sequencer stage: owns the PC, handshakes with the fetch/decode unit
// and runs each instruction against an accumulator, flags and a small data memory.
module seq_exec_unit #(
    parameter int unsigned INST_CAP = 20,
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned DMEM_CAP = 16,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    output logic                          fetch_en,
    output logic [$clog2(INST_CAP):0]     pc,
    input  logic                          is_ready,
    input  logic [3:0]                    control_bus,
    input  logic [DATA_LEN-1:0]           data,
    output logic [DATA_LEN-1:0]           acc,
    output logic                          zf,
    output logic                          cf,
    output logic [DATA_LEN-1:0]           out_data,
    output logic                          out_valid,
    output logic                          halted,
    output logic                          fault
);

    localparam int unsigned PC_W  = $clog2(INST_CAP) + 1;
    localparam int unsigned AW    = $clog2(DMEM_CAP);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_NOP  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_SUBI = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [3:0]          ir_op, ir_op_nxt;
    logic [DATA_LEN-1:0] ir_data, ir_data_nxt;
    logic [DATA_LEN-1:0] dmem [DMEM_CAP];

    logic [PC_W-1:0]     pc_nxt;
    logic [DATA_LEN-1:0] acc_nxt, out_data_nxt;
    logic                zf_nxt, cf_nxt, out_valid_nxt, fault_nxt, fetch_en_nxt, halted_nxt;
    logic                dmem_we;
    logic                upd_z;

    logic [AW-1:0]       maddr_c;
    logic [DATA_LEN-1:0] mrd_c;
    logic [DATA_LEN-1:0] opnd_c;
    logic [DATA_LEN:0]   sum_c, diff_c;
    logic [PC_W-1:0]     pc_inc_c;
    logic                jump_taken_c, jump_bad_c, timeout_c;

    // Operand fetch, arithmetic and jump decode shared by FSM and datapath
    always_comb begin
        maddr_c      = ir_data[AW-1:0];
        mrd_c        = dmem[maddr_c];
        opnd_c       = (ir_op == OP_ADDI || ir_op == OP_SUBI) ? ir_data : mrd_c;
        sum_c        = {1'b0, acc} + {1'b0, opnd_c};
        diff_c       = {1'b0, acc} - {1'b0, opnd_c};
        pc_inc_c     = (pc == PC_W'(INST_CAP - 1)) ? '0 : pc + PC_W'(1);
        jump_taken_c = (ir_op == OP_JMP) || (ir_op == OP_JZ && zf) || (ir_op == OP_JC && cf);
        jump_bad_c   = (ir_data >= DATA_LEN'(INST_CAP));
        timeout_c    = (cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (is_ready)       state_nxt = S_EXEC;
                else if (timeout_c) state_nxt = S_HALT;
            end
            S_EXEC: begin
                if (ir_op == OP_HLT || (jump_taken_c && jump_bad_c)) state_nxt = S_HALT;
                else                                                 state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        acc_nxt       = acc;
        zf_nxt        = zf;
        cf_nxt        = cf;
        pc_nxt        = pc;
        out_data_nxt  = out_data;
        out_valid_nxt = 1'b0;
        fault_nxt     = fault;
        cnt_nxt       = '0;
        ir_op_nxt     = ir_op;
        ir_data_nxt   = ir_data;
        dmem_we       = 1'b0;
        upd_z         = 1'b0;
        fetch_en_nxt  = (state_nxt == S_FETCH);
        halted_nxt    = (state_nxt == S_HALT);
        case (state)
            S_WAIT: begin
                if (is_ready) begin
                    ir_op_nxt   = control_bus;
                    ir_data_nxt = data;
                end else if (timeout_c) begin
                    fault_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_EXEC: begin
                pc_nxt = pc_inc_c;
                case (ir_op)
                    OP_LDI:  begin acc_nxt = ir_data;        upd_z = 1'b1; end
                    OP_LDA:  begin acc_nxt = mrd_c;          upd_z = 1'b1; end
                    OP_STA:  dmem_we = 1'b1;
                    OP_ADD, OP_ADDI: begin
                        {cf_nxt, acc_nxt} = sum_c;
                        upd_z = 1'b1;
                    end
                    OP_SUB, OP_SUBI: begin
                        {cf_nxt, acc_nxt} = diff_c;
                        upd_z = 1'b1;
                    end
                    OP_AND:  begin acc_nxt = acc & mrd_c;    upd_z = 1'b1; end
                    OP_OR:   begin acc_nxt = acc | mrd_c;    upd_z = 1'b1; end
                    OP_NOT:  begin acc_nxt = ~acc;           upd_z = 1'b1; end
                    OP_OUT:  begin out_data_nxt = acc; out_valid_nxt = 1'b1; end
                    OP_HLT:  pc_nxt = pc;
                    default: ;
                endcase
                if (upd_z) zf_nxt = (acc_nxt == '0);
                // Out-of-range jump target halts with the PC left on the jump
                if (jump_taken_c) begin
                    if (jump_bad_c) begin
                        pc_nxt    = pc;
                        fault_nxt = 1'b1;
                    end else begin
                        pc_nxt = PC_W'(ir_data);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc        <= '0;
            acc       <= '0;
            zf        <= 1'b0;
            cf        <= 1'b0;
            fetch_en  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
            cnt       <= '0;
            ir_op     <= OP_NOP;
            ir_data   <= '0;
        end else begin
            pc        <= pc_nxt;
            acc       <= acc_nxt;
            zf        <= zf_nxt;
            cf        <= cf_nxt;
            fetch_en  <= fetch_en_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            halted    <= halted_nxt;
            fault     <= fault_nxt;
            cnt       <= cnt_nxt;
            ir_op     <= ir_op_nxt;
            ir_data   <= ir_data_nxt;
        end
    end

    // Data memory
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DMEM_CAP; i++) dmem[i] <= '0;
        end else if (dmem_we) begin
            dmem[maddr_c] <= acc;
        end
    end

endmodule
